// File: rtl/ines_pkg.sv
// Shared definitions for the iNES ROM loader: FSM states, header magic,
// region sizes and error codes. NES 2.0 size extension is selected by the
// INES_NES2_EN macro in ines_loader.
package ines_pkg;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_TRN   = 3'd1,
    S_PRG   = 3'd2,
    S_CHR   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam logic [31:0] INES_MAGIC = 32'h4E45531A;

  localparam int HDR_LEN       = 16;
  localparam int TRAINER_LEN   = 512;
  localparam int PRG_UNIT      = 16384;
  localparam int CHR_UNIT      = 8192;
  localparam int PRG_MAX_UNITS = 128;
  localparam int CHR_MAX_UNITS = 256;

  localparam int ADDR_W = 22;
  localparam int FIFO_W = ADDR_W + 8;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MAGIC    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  // Expected header byte at position idx (0..3) of the magic word.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INES_MAGIC[31:24];
      2'd1:    b = INES_MAGIC[23:16];
      2'd2:    b = INES_MAGIC[15:8];
      default: b = INES_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ines_fifo.sv
// Synchronous payload FIFO with a registered head entry. The head register is
// loaded with the entry that will be at the front after this cycle's push/pop,
// so a push into an empty FIFO is visible on the head one cycle later.
// Handshake: push is honoured when not full or when a pop happens in the same
// cycle; pop is honoured when not empty; flush discards everything.
module ines_fifo
  import ines_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FIFO_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             do_push, do_pop;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;

  // Next pointers, occupancy and the entry that becomes the registered head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_valid_d = (count_d != '0);
    // The pushed word becomes the head only when nothing older remains.
    if (do_push && (rd_ptr_d == wr_ptr_q)) head_data_d = push_data;
    else                                   head_data_d = mem_q[rd_ptr_d];
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end
  end

  // Storage array; written on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

endmodule

// File: rtl/ines_loader.sv
// iNES ROM stream loader: parses the 16-byte header, skips the optional
// trainer and writes PRG then CHR bytes to memory through a FIFO.
// Optional NES 2.0 size extension: define INES_NES2_EN.
// Memory handshake: a write completes on a cycle where mem_write and mem_ack
// are both high; mem_addr/mem_data/mem_write hold while mem_write && !mem_ack
// (except after an error, when the pending write is discarded).
module ines_loader
  import ines_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [21:0] CHR_BASE   = 22'h200000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [7:0]  mapper,
  output logic        mirroring,
  output logic        battery,
  output logic        four_screen,
  output logic [11:0] prg_size,
  output logic [11:0] chr_size,
  output logic [2:0]  dbg_state_o
);

  state_e      state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [21:0] rem_q, rem_d;
  logic [21:0] addr_q, addr_d;
  logic [11:0] prg_q, prg_d;
  logic [11:0] chr_q, chr_d;
  logic [7:0]  f6_q, f6_d;
  logic [3:0]  f7_hi_q, f7_hi_d;
  logic [1:0]  err_q, err_d;
  logic        busy_q, busy_d;
`ifdef INES_NES2_EN
  logic        nes2_q, nes2_d;
`endif

  logic              push, flush;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              head_valid;
  logic [FIFO_W-1:0] head_data;
  logic              size_bad;
  logic [21:0]       prg_bytes, chr_bytes;

  assign size_bad  = (prg_q == '0) || (prg_q > 12'(PRG_MAX_UNITS)) ||
                     (chr_q > 12'(CHR_MAX_UNITS));
  assign prg_bytes = 22'(prg_q) * 22'(PRG_UNIT);
  assign chr_bytes = 22'(chr_q) * 22'(CHR_UNIT);
  assign fifo_pop  = head_valid && mem_ack;

  ines_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data ({addr_q, din}),
    .pop       (fifo_pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_valid(head_valid),
    .head_data (head_data)
  );

  // Next-state logic: header parse, trainer skip, payload push, completion.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    prg_d     = prg_q;
    chr_d     = chr_q;
    f6_d      = f6_q;
    f7_hi_d   = f7_hi_q;
    err_d     = err_q;
`ifdef INES_NES2_EN
    nes2_d    = nes2_q;
`endif
    push      = 1'b0;

    case (state_q)
      S_HDR: begin
        if (din_valid) begin
          hdr_idx_d = hdr_idx_q + 4'd1;
          case (hdr_idx_q)
            4'd0, 4'd1, 4'd2, 4'd3: begin
              if (din != magic_byte(hdr_idx_q[1:0])) begin
                state_d = S_ERR;
                err_d   = ERR_MAGIC;
              end
            end
            4'd4: prg_d = {4'h0, din};
            4'd5: chr_d = {4'h0, din};
            4'd6: f6_d  = din;
            4'd7: begin
              f7_hi_d = din[7:4];
`ifdef INES_NES2_EN
              nes2_d  = (din[3:2] == 2'b10);
`endif
            end
`ifdef INES_NES2_EN
            4'd9: begin
              if (nes2_q) begin
                prg_d[11:8] = din[3:0];
                chr_d[11:8] = din[7:4];
              end
            end
`endif
            4'(HDR_LEN - 1): begin
              if (size_bad) begin
                state_d = S_ERR;
                err_d   = ERR_SIZE;
              end else if (f6_q[2]) begin
                state_d = S_TRN;
                rem_d   = 22'(TRAINER_LEN);
              end else begin
                state_d = S_PRG;
                rem_d   = prg_bytes;
                addr_d  = '0;
              end
            end
            default: ;
          endcase
        end
      end

      S_TRN: begin
        if (din_valid) begin
          rem_d = rem_q - 22'd1;
          if (rem_q == 22'd1) begin
            state_d = S_PRG;
            rem_d   = prg_bytes;
            addr_d  = '0;
          end
        end
      end

      S_PRG, S_CHR: begin
        if (din_valid) begin
          if (fifo_full && !fifo_pop) begin
            state_d = S_ERR;
            err_d   = ERR_OVERFLOW;
          end else begin
            push   = 1'b1;
            addr_d = addr_q + 22'd1;
            rem_d  = rem_q - 22'd1;
            if (rem_q == 22'd1) begin
              if ((state_q == S_PRG) && (chr_q != '0)) begin
                state_d = S_CHR;
                addr_d  = CHR_BASE;
                rem_d   = chr_bytes;
              end else begin
                state_d = S_FLUSH;
              end
            end
          end
        end
      end

      S_FLUSH: begin
        if (fifo_empty && !head_valid) state_d = S_DONE;
      end

      default: ;
    endcase

    busy_d = (busy_q || din_valid) && (state_d != S_DONE) && (state_d != S_ERR);
    flush  = (state_d == S_ERR);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_HDR;
      hdr_idx_q <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      prg_q     <= '0;
      chr_q     <= '0;
      f6_q      <= '0;
      f7_hi_q   <= '0;
      err_q     <= ERR_NONE;
      busy_q    <= 1'b0;
`ifdef INES_NES2_EN
      nes2_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      prg_q     <= prg_d;
      chr_q     <= chr_d;
      f6_q      <= f6_d;
      f7_hi_q   <= f7_hi_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef INES_NES2_EN
      nes2_q    <= nes2_d;
`endif
    end
  end

  assign mem_write   = head_valid;
  assign mem_addr    = head_data[FIFO_W-1:8];
  assign mem_data    = head_data[7:0];
  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign err_code    = err_q;
  assign mapper      = {f7_hi_q, f6_q[7:4]};
  assign mirroring   = f6_q[0];
  assign battery     = f6_q[1];
  assign four_screen = f6_q[3];
  assign prg_size    = prg_q;
  assign chr_size    = chr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ines_loader.sv
// Self-checking bench for ines_loader: an image-level model turns each ROM
// image into the list of memory writes and the final status it must produce.
module tb_ines_loader;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [21:0] CHR_BASE   = 22'h200000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write, busy, done, error;
  logic [1:0]  err_code;
  logic [7:0]  mapper;
  logic        mirroring, battery, four_screen;
  logic [11:0] prg_size, chr_size;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  ines_loader #(.FIFO_DEPTH(FIFO_DEPTH), .CHR_BASE(CHR_BASE)) dut (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mem_ack(mem_ack), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .mapper(mapper), .mirroring(mirroring),
    .battery(battery), .four_screen(four_screen), .prg_size(prg_size),
    .chr_size(chr_size), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [29:0] exp_q[$];
  logic [7:0]  img[];
  int          ack_mode = 0;   // 0 high, 1 low, 2 random (never low twice)
  logic        ack_last_low = 1'b0;
  int          mw_cycles = 0;
  logic        mw_prev = 1'b0, ack_prev = 1'b0;
  logic [21:0] addr_prev = '0;
  logic [7:0]  data_prev = '0;
  logic [29:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ack driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = 1'b0;
        default: mem_ack = ack_last_low ? 1'b1 : ($urandom_range(0, 1) == 1);
      endcase
      ack_last_low = !mem_ack;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      mw_prev  = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (mw_prev && !ack_prev && !error) begin
        check("stall_write", mem_write, 1'b1);
        check("stall_addr", mem_addr, addr_prev);
        check("stall_data", mem_data, data_prev);
      end
      if (mem_write) mw_cycles++;
      if (mem_write && mem_ack) begin
        if (exp_q.size() == 0) begin
          check("write_when_none_expected", mem_write, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e[29:8]);
          check("wr_data", mem_data, e[7:0]);
        end
      end
      mw_prev   = mem_write;
      ack_prev  = mem_ack;
      addr_prev = mem_addr;
      data_prev = mem_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int from, input int to, input int gap_min, input int gap_max);
    for (int i = from; i <= to; i++) begin
      din       = img[i];
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      repeat ($urandom_range(gap_min, gap_max)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    resetn    = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    resetn    = 1'b1;
    exp_q.delete();
    mw_cycles = 0;
  endtask

  // Builds a header plus payload_n random bytes (payload_n < 0: full image + 3 trailing).
  task automatic make_image(input logic [7:0] prg, input logic [7:0] chr,
                            input logic [7:0] f6, input logic [7:0] f7, input int payload_n);
    int n;
    n = payload_n;
    if (n < 0) n = (f6[2] ? 512 : 0) + int'(prg) * 16384 + int'(chr) * 8192 + 3;
    img = new[16 + n];
    for (int i = 0; i < 16 + n; i++) img[i] = 8'($urandom);
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
    img[4] = prg;   img[5] = chr;   img[6] = f6;    img[7] = f7;
  endtask

  // Reference model: expected writes and final error code from image rules.
  task automatic build_expect(input bit hdr_only, output logic [1:0] exp_err);
    int prg, chr, off;
    exp_q.delete();
    if (img[0] !== 8'h4E || img[1] !== 8'h45 || img[2] !== 8'h53 || img[3] !== 8'h1A) begin
      exp_err = 2'd1;
      return;
    end
    prg = int'(img[4]);
    chr = int'(img[5]);
`ifdef INES_NES2_EN
    if (img[7][3:2] == 2'b10) begin
      prg = prg + int'(img[9][3:0]) * 256;
      chr = chr + int'(img[9][7:4]) * 256;
    end
`endif
    if (prg == 0 || prg > 128 || chr > 256) begin
      exp_err = 2'd3;
      return;
    end
    exp_err = 2'd0;
    if (hdr_only) return;
    off = 16 + (img[6][2] ? 512 : 0);
    for (int i = 0; i < prg * 16384; i++) exp_q.push_back({22'(i), img[off + i]});
    off = off + prg * 16384;
    for (int i = 0; i < chr * 8192; i++) exp_q.push_back({CHR_BASE + 22'(i), img[off + i]});
  endtask

  task automatic check_header(input string tag);
    check({tag, "_mapper"}, mapper, {img[7][7:4], img[6][7:4]});
    check({tag, "_mirroring"}, mirroring, img[6][0]);
    check({tag, "_battery"}, battery, img[6][1]);
    check({tag, "_four_screen"}, four_screen, img[6][3]);
    check({tag, "_prg_size"}, prg_size, {4'h0, img[4]});
    check({tag, "_chr_size"}, chr_size, {4'h0, img[5]});
  endtask

  task automatic check_end(input string tag, input logic [1:0] exp_err);
    int n;
    n = 0;
    while (!(done || error) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_finished"}, done || error, 1'b1);
    check({tag, "_done"}, done, exp_err == 2'd0);
    check({tag, "_error"}, error, exp_err != 2'd0);
    check({tag, "_err_code"}, err_code, exp_err);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_mem_write"}, mem_write, 1'b0);
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  // Header-only image checked around byte 15 for the size rules.
  task automatic hdr_test(input string tag, input logic [7:0] prg, input logic [7:0] chr,
                          input logic [7:0] f7, input logic [7:0] b9, input logic [1:0] lit_err);
    logic [1:0] exp_err;
    do_reset();
    ack_mode = 0;
    make_image(prg, chr, 8'h00, f7, 0);
    img[9] = b9;
    build_expect(1'b1, exp_err);
    check({tag, "_model"}, exp_err, lit_err);
    drive(0, 14, 0, 0);
    check({tag, "_no_err_b14"}, error, 1'b0);
    drive(15, 15, 0, 0);
    check({tag, "_error_b15"}, error, exp_err != 2'd0);
    check({tag, "_code_b15"}, err_code, exp_err);
    check({tag, "_busy_b15"}, busy, exp_err == 2'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] exp_err;
    logic [7:0] f6, f7;

    // Reset state
    do_reset();
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_code", err_code, 2'd0);
    check("rst_mapper", mapper, 8'h00);
    check("rst_prg_size", prg_size, 12'h000);
    check("rst_chr_size", chr_size, 12'h000);

    // Test 1: PRG=1 CHR=1, ack always high, back-to-back bytes
    ack_mode = 0;
    make_image(8'd1, 8'd1, 8'h01, 8'h00, -1);
    build_expect(1'b0, exp_err);
    check("t1_model_count", exp_q.size(), 24576);
    check("t1_model_prg_last", exp_q[16383][29:8], 22'd16383);
    check("t1_model_chr_first", exp_q[16384][29:8], 22'h200000);
    check("t1_model_chr_last", exp_q[24575][29:8], 22'h201FFF);
    check("t1_busy_idle", busy, 1'b0);
    drive(0, 16, 0, 0);
    check("t1_latency_write", mem_write, 1'b1);
    check("t1_latency_addr", mem_addr, 22'h0);
    check("t1_latency_data", mem_data, img[16]);
    check("t1_busy_loading", busy, 1'b1);
    check("t1_mirroring_lit", mirroring, 1'b1);
    check("t1_mapper_lit", mapper, 8'h00);
    drive(17, img.size() - 1, 0, 0);
    check_end("t1", exp_err);
    check_header("t1");

    // Test 2: reset mid-PRG while a write is stalled
    do_reset();
    ack_mode = 1;
    make_image(8'd1, 8'd1, 8'hF1, 8'hF0, 3);
    drive(0, 18, 0, 0);
    check("t2_stalled_write", mem_write, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("t2_rst_mem_write", mem_write, 1'b0);
    check("t2_rst_busy", busy, 1'b0);
    check("t2_rst_done", done, 1'b0);
    check("t2_rst_error", error, 1'b0);
    check("t2_rst_err_code", err_code, 2'd0);
    check("t2_rst_mapper", mapper, 8'h00);
    check("t2_rst_flags", {mirroring, battery, four_screen}, 3'b000);
    check("t2_rst_sizes", {prg_size, chr_size}, 24'h0);
    resetn = 1'b1;
    exp_q.delete();
    mw_cycles = 0;

    // Test 3: fresh image after reset, with trainer and random flags
    ack_mode = 0;
    f6 = 8'($urandom) | 8'h04;
    f7 = 8'($urandom) & 8'hF0;
    make_image(8'd1, 8'd0, f6, f7, -1);
    build_expect(1'b0, exp_err);
    check("t3_model_count", exp_q.size(), 16384);
    check("t3_model_first", exp_q[0], {22'h0, img[528]});
    drive(0, img.size() - 1, 0, 0);
    check_end("t3", exp_err);
    check_header("t3");

    // Test 4: random ack, one idle cycle between bytes, CHR=0
    do_reset();
    ack_mode = 2;
    f6 = 8'($urandom) & 8'hFB;
    f7 = 8'($urandom) & 8'hF0;
    make_image(8'd1, 8'd0, f6, f7, -1);
    build_expect(1'b0, exp_err);
    drive(0, img.size() - 1, 1, 1);
    check_end("t4", exp_err);
    check_header("t4");

    // Test 5: bad magic at byte 3
    do_reset();
    ack_mode = 0;
    make_image(8'd1, 8'd0, 8'h00, 8'h00, 6);
    img[3] = 8'h1B;
    build_expect(1'b0, exp_err);
    check("t5_model", exp_err, 2'd1);
    drive(0, img.size() - 1, 0, 0);
    check_end("t5", exp_err);
    check("t5_no_mem_write", mw_cycles, 0);

    // Test 6: FIFO overflow with ack held low
    do_reset();
    ack_mode = 1;
    make_image(8'd1, 8'd0, 8'h00, 8'h00, 5);
    drive(0, 20, 0, 0);
    check("t6_error", error, 1'b1);
    check("t6_err_code", err_code, 2'd2);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("t6_mem_write_low", mem_write, 1'b0);
    check("t6_some_writes_pending", mw_cycles > 0, 1'b1);

    // Test 7: size range checks at byte 15
    hdr_test("sz_prg0", 8'h00, 8'h01, 8'h00, 8'h00, 2'd3);
    hdr_test("sz_prg81", 8'h81, 8'h01, 8'h00, 8'h00, 2'd3);
    hdr_test("sz_prg80", 8'h80, 8'h00, 8'h00, 8'h00, 2'd0);
    hdr_test("sz_chrff", 8'h01, 8'hFF, 8'h00, 8'h00, 2'd0);
    check("sz_chrff_chr_size", chr_size, 12'h0FF);
`ifdef INES_NES2_EN
    hdr_test("sz_nes2", 8'h01, 8'h01, 8'h08, 8'h01, 2'd3);
    check("sz_nes2_prg_size", prg_size, 12'h101);
`else
    hdr_test("sz_nes2_off", 8'h01, 8'h01, 8'h08, 8'h01, 2'd0);
    check("sz_nes2_off_prg_size", prg_size, 12'h001);
`endif

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
